req_gnt_monitor: RTL and testbench
==================================

# req_gnt_monitor

Synthesizable, parametrised request/grant protocol monitor bound alongside a design block. Checks NUM_CH independent req/gnt channels against a per-trigger rule: either grant stability at a fixed delay after a started request, or grant arrival within a bounded window. Reports per-channel pass/fail pulses, sticky error flags, saturating aggregate counters and the first failing channel. Runs in silicon or simulation, with no dependence on simulator assertion support.

## Interface
- NUM_CH, 4, number of monitored req/gnt channels (1..32)
- DELAY, 2, check depth in cycles after trigger (>=1)
- CNT_W, 16, width of aggregate pass/fail counters
- clk  in  1  sampling clock, all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- en  in  1  global enable; gates new triggers only
- start  in  1  qualifier; trigger on channel i = en & start & req[i]
- mode  in  1  0 = STABLE, 1 = GRANT; sampled per channel at its trigger
- req  in  NUM_CH  request per channel
- gnt  in  NUM_CH  grant per channel
- clr  in  1  synchronous clear of sticky flags, counters and first-fail capture
- busy  out  NUM_CH  channel has a check in flight
- pass_p  out  NUM_CH  one-cycle pass pulse
- fail_p  out  NUM_CH  one-cycle fail pulse
- overlap_p  out  NUM_CH  one-cycle pulse: trigger arrived while busy and was not an accept
- err  out  NUM_CH  sticky fail flag
- pass_cnt  out  CNT_W  saturating total passes
- fail_cnt  out  CNT_W  saturating total fails
- first_fail_vld  out  1  a fail is captured
- first_fail_ch  out  $clog2(NUM_CH) (min 1)  index of first failing channel

## Operation
- Per-channel FSM: IDLE, CHECK. IDLE->CHECK on trigger; latches mode, clears cycle count cnt (width $clog2(DELAY+1)).
- CHECK, cnt increments every edge. Result is evaluated at edge k, where k = 1..DELAY counts edges after trigger edge T.
- STABLE: evaluated only at k=DELAY. Pass if gnt[i] at T+DELAY equals gnt[i] at T+DELAY-1, else fail. Previous-gnt register per channel is always updated.
- GRANT: pass at the first k in 1..DELAY with gnt[i]=1. Fail if gnt[i]=0 at k=DELAY.
- On evaluation edge the FSM returns IDLE. A trigger on that same edge is accepted (back-to-back, no overlap_p).
- Trigger while in CHECK and not on the evaluation edge: ignored, overlap_p[i] pulses, in-flight check unaffected.
- en=0 blocks triggers only; in-flight checks complete normally.
- err[i] is set on fail_p[i] and held until clr or reset.
- Counters add popcount of pass_p / fail_p each cycle and saturate at 2^CNT_W-1, with no wrap.
- first_fail_ch captures on the first fail while first_fail_vld=0. On simultaneous fails the lowest index wins.
- clr: sticky flags, counters and first-fail are zeroed. Events on the clr edge are then applied, so the post-clear value reflects them. In-flight checks are not aborted.

## Timing
- Outputs are registered. pass_p/fail_p are high in the cycle following the evaluation edge, giving a latency of DELAY cycles after trigger (STABLE) or k cycles (GRANT).
- busy[i] is high from the cycle after the trigger edge through the cycle before the result pulse. It stays high continuously across back-to-back accepts.
- Counters, err and first_fail update in the same cycle as the pulses.
- Reset (rst_n=0 at an edge): every FSM goes IDLE. All outputs are 0: busy, pulses, err, counters, first_fail_vld, first_fail_ch. Previous-gnt registers are 0. Reset mid-check discards the check with no result pulse.

## Structure
- Package req_gnt_mon_pkg: mode_e {MODE_STABLE, MODE_GRANT}, chan_state_e {IDLE, CHECK}, result struct {pass, fail, overlap}.
- Sub-module req_gnt_mon_chan (one channel FSM, cnt, prev-gnt, latched mode). Instantiated NUM_CH times by generate.
- Top module: popcount, saturating counters, sticky flags, first-fail priority encoder.

## Test plan
- STABLE, DELAY=2, ch0: req=1, start=1 at edge 1; gnt=0 throughout -> pass_p[0] in cycle after edge 3, pass_cnt=1.
- STABLE, DELAY=2, ch0: trigger edge 1; gnt goes 0->1 between edges 2 and 3 -> fail_p[0], err[0]=1, first_fail_ch=0.
- GRANT, DELAY=4, ch2: gnt rises before edge 3 after trigger -> pass at k=3, busy[2] low one cycle later. Repeat with no gnt -> fail at k=4.
- Overlap/back-to-back, DELAY=3, ch1: trigger at T and T+1 -> overlap_p[1] at T+1. Trigger at T+3 -> accepted, no overlap.
- Simultaneous fails on ch3 and ch1 -> fail_cnt +=2, first_fail_ch=1. clr on same edge as a new pass -> pass_cnt=1, err cleared.
- CNT_W=2: 5 passes -> pass_cnt saturates at 3. Then rst_n=0 mid-check -> all outputs 0, no pulse.

Source files
------------

// File: rtl/req_gnt_mon_pkg.sv
// Shared types for the req/gnt protocol monitor: check mode, channel FSM
// state and the per-edge result of one channel.
package req_gnt_mon_pkg;

  typedef enum logic {
    MODE_STABLE = 1'b0,
    MODE_GRANT  = 1'b1
  } mode_e;

  typedef enum logic {
    IDLE  = 1'b0,
    CHECK = 1'b1
  } chan_state_e;

  typedef struct packed {
    logic pass;
    logic fail;
    logic overlap;
  } result_t;

endpackage

// File: rtl/req_gnt_mon_chan.sv
// One monitored req/gnt channel: IDLE/CHECK FSM, edge counter, latched mode
// and previous-gnt register. Result is combinational for the current edge.
module req_gnt_mon_chan
  import req_gnt_mon_pkg::*;
#(
  parameter int DELAY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        trig,
  input  logic        mode,
  input  logic        gnt,
  output chan_state_e state,
  output result_t     res
);

  localparam int CW = $clog2(DELAY + 1);
  localparam logic [CW-1:0] LAST = CW'(DELAY - 1);

  chan_state_e   state_d;
  logic [CW-1:0] cnt, cnt_d;
  mode_e         mode_q, mode_d;
  logic          prev_gnt;
  logic          eval;

  // cnt holds k-1 at the edge being evaluated, so LAST marks k == DELAY.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    mode_d  = mode_q;
    res     = '0;
    eval    = 1'b0;
    case (state)
      IDLE: begin
        if (trig) begin
          state_d = CHECK;
          cnt_d   = '0;
          mode_d  = mode_e'(mode);
        end
      end
      CHECK: begin
        cnt_d = cnt + 1'b1;
        if (mode_q == MODE_STABLE) begin
          if (cnt == LAST) begin
            eval     = 1'b1;
            res.pass = (gnt == prev_gnt);
            res.fail = (gnt != prev_gnt);
          end
        end else if (gnt) begin
          eval     = 1'b1;
          res.pass = 1'b1;
        end else if (cnt == LAST) begin
          eval     = 1'b1;
          res.fail = 1'b1;
        end
        if (eval) begin
          if (trig) begin
            cnt_d  = '0;
            mode_d = mode_e'(mode);
          end else begin
            state_d = IDLE;
          end
        end else if (trig) begin
          res.overlap = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      mode_q   <= MODE_STABLE;
      prev_gnt <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      mode_q   <= mode_d;
      prev_gnt <= gnt;
    end
  end

endmodule

// File: rtl/req_gnt_monitor.sv
// Request/grant protocol monitor: NUM_CH channel checkers plus registered
// pulses, sticky errors, saturating counters and first-fail capture.
module req_gnt_monitor
  import req_gnt_mon_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DELAY  = 2,
  parameter int CNT_W  = 16,
  localparam int FF_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              start,
  input  logic              mode,
  input  logic [NUM_CH-1:0] req,
  input  logic [NUM_CH-1:0] gnt,
  input  logic              clr,
  output logic [NUM_CH-1:0] busy,
  output logic [NUM_CH-1:0] pass_p,
  output logic [NUM_CH-1:0] fail_p,
  output logic [NUM_CH-1:0] overlap_p,
  output logic [NUM_CH-1:0] err,
  output logic [CNT_W-1:0]  pass_cnt,
  output logic [CNT_W-1:0]  fail_cnt,
  output logic              first_fail_vld,
  output logic [FF_W-1:0]   first_fail_ch
);

  localparam int PW = $clog2(NUM_CH + 1);
  localparam int SW = CNT_W + PW;
  localparam logic [SW-1:0] SAT = SW'({CNT_W{1'b1}});

  logic [NUM_CH-1:0] trig, pass_d, fail_d, ovl_d, err_d;
  logic [PW-1:0]     npass, nfail;
  logic [SW-1:0]     sum_p, sum_f;
  logic [CNT_W-1:0]  pass_cnt_d, fail_cnt_d;
  logic              ffv_d, found;
  logic [FF_W-1:0]   ffc_d;

  assign trig = {NUM_CH{en & start}} & req;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    chan_state_e st;
    result_t     res;
    req_gnt_mon_chan #(.DELAY(DELAY)) u_chan (
      .clk   (clk),
      .rst_n (rst_n),
      .trig  (trig[g]),
      .mode  (mode),
      .gnt   (gnt[g]),
      .state (st),
      .res   (res)
    );
    assign busy[g]   = (st == CHECK);
    assign pass_d[g] = res.pass;
    assign fail_d[g] = res.fail;
    assign ovl_d[g]  = res.overlap;
  end

  // clr zeroes the bases first so events on the clr edge still land.
  always_comb begin
    npass = '0;
    nfail = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      npass = npass + PW'(pass_d[i]);
      nfail = nfail + PW'(fail_d[i]);
    end
    sum_p      = (clr ? '0 : SW'(pass_cnt)) + SW'(npass);
    sum_f      = (clr ? '0 : SW'(fail_cnt)) + SW'(nfail);
    pass_cnt_d = (sum_p > SAT) ? {CNT_W{1'b1}} : sum_p[CNT_W-1:0];
    fail_cnt_d = (sum_f > SAT) ? {CNT_W{1'b1}} : sum_f[CNT_W-1:0];
    err_d      = (clr ? '0 : err) | fail_d;
    ffv_d      = clr ? 1'b0 : first_fail_vld;
    ffc_d      = clr ? '0 : first_fail_ch;
    found      = 1'b0;
    if (!ffv_d) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (fail_d[i] && !found) begin
          found = 1'b1;
          ffc_d = FF_W'(i);
        end
      end
    end
    if (found) ffv_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pass_p         <= '0;
      fail_p         <= '0;
      overlap_p      <= '0;
      err            <= '0;
      pass_cnt       <= '0;
      fail_cnt       <= '0;
      first_fail_vld <= 1'b0;
      first_fail_ch  <= '0;
    end else begin
      pass_p         <= pass_d;
      fail_p         <= fail_d;
      overlap_p      <= ovl_d;
      err            <= err_d;
      pass_cnt       <= pass_cnt_d;
      fail_cnt       <= fail_cnt_d;
      first_fail_vld <= ffv_d;
      first_fail_ch  <= ffc_d;
    end
  end

endmodule

// File: tb/tb_req_gnt_monitor.sv
// Scoreboard bench for req_gnt_monitor: a time-based reference model queues
// the expected output snapshot for every edge; a monitor pops and compares.
module tb_req_gnt_monitor;

  localparam int NUM_CH = 4;
  localparam int DELAY  = 3;
  localparam int CNT_W  = 3;
  localparam int FF_W   = 2;
  localparam int OW     = 5 * NUM_CH + 2 * CNT_W + 1 + FF_W;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              en = 1'b0, start = 1'b0, mode = 1'b0, clr = 1'b0;
  logic [NUM_CH-1:0] req = '0, gnt = '0;
  logic [NUM_CH-1:0] busy, pass_p, fail_p, overlap_p, err;
  logic [CNT_W-1:0]  pass_cnt, fail_cnt;
  logic              first_fail_vld;
  logic [FF_W-1:0]   first_fail_ch;

  req_gnt_monitor #(.NUM_CH(NUM_CH), .DELAY(DELAY), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .en             (en),
    .start          (start),
    .mode           (mode),
    .req            (req),
    .gnt            (gnt),
    .clr            (clr),
    .busy           (busy),
    .pass_p         (pass_p),
    .fail_p         (fail_p),
    .overlap_p      (overlap_p),
    .err            (err),
    .pass_cnt       (pass_cnt),
    .fail_cnt       (fail_cnt),
    .first_fail_vld (first_fail_vld),
    .first_fail_ch  (first_fail_ch)
  );

  always #5 clk = ~clk;

  logic [OW-1:0] exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  // Reference model: a check is remembered as (trigger edge, mode); results
  // follow from the edge distance and the recorded gnt of the previous edge.
  int          n = 0;
  bit          m_act[NUM_CH];
  int          m_t0[NUM_CH];
  bit          m_md[NUM_CH];
  bit          m_gp[NUM_CH];
  int          m_pc = 0, m_fc = 0, m_ffc = 0;
  bit          m_ffv = 0;
  logic [NUM_CH-1:0] m_err = '0;

  task automatic model_step(input logic r, e, s, m, input logic [NUM_CH-1:0] rq, gt,
                            input logic c);
    logic [NUM_CH-1:0] p, f, o, b;
    int k;
    bit done, t;
    p = '0; f = '0; o = '0; b = '0;
    n++;
    if (!r) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        m_act[ch] = 0;
        m_gp[ch]  = 0;
      end
      m_pc = 0; m_fc = 0; m_err = '0; m_ffv = 0; m_ffc = 0;
    end else begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        t = e & s & rq[ch];
        if (m_act[ch]) begin
          k    = n - m_t0[ch];
          done = 0;
          if (!m_md[ch]) begin
            if (k == DELAY) begin
              done = 1;
              if (gt[ch] == m_gp[ch]) p[ch] = 1; else f[ch] = 1;
            end
          end else if (gt[ch]) begin
            done = 1; p[ch] = 1;
          end else if (k == DELAY) begin
            done = 1; f[ch] = 1;
          end
          if (done) m_act[ch] = 0;
          else if (t) o[ch] = 1;
        end
        if (!m_act[ch] && t) begin
          m_act[ch] = 1;
          m_t0[ch]  = n;
          m_md[ch]  = m;
        end
        m_gp[ch] = gt[ch];
        b[ch]    = m_act[ch];
      end
      if (c) begin
        m_pc = 0; m_fc = 0; m_err = '0; m_ffv = 0; m_ffc = 0;
      end
      m_pc  = (m_pc + $countones(p) > CMAX) ? CMAX : m_pc + $countones(p);
      m_fc  = (m_fc + $countones(f) > CMAX) ? CMAX : m_fc + $countones(f);
      m_err = m_err | f;
      if (!m_ffv && f != 0) begin
        m_ffv = 1;
        for (int ch = NUM_CH - 1; ch >= 0; ch--) if (f[ch]) m_ffc = ch;
      end
    end
    exp_q.push_back({b, p, f, o, m_err, CNT_W'(m_pc), CNT_W'(m_fc), m_ffv, FF_W'(m_ffc)});
  endtask

  task automatic drive(input logic r, e, s, m, input logic [NUM_CH-1:0] rq, gt,
                       input logic c);
    @(negedge clk);
    rst_n = r; en = e; start = s; mode = m; req = rq; gnt = gt; clr = c;
    model_step(r, e, s, m, rq, gt, c);
  endtask

  task automatic idle(input int cycles, input logic [NUM_CH-1:0] gt);
    for (int i = 0; i < cycles; i++) drive(1, 1, 0, 0, '0, gt, 0);
  endtask

  initial begin : monitor
    logic [OW-1:0] exp_v, got_v;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        got_v = {busy, pass_p, fail_p, overlap_p, err, pass_cnt, fail_cnt,
                 first_fail_vld, first_fail_ch};
        vectors++;
        if (got_v !== exp_v) begin
          miscompares++;
          $display("FAIL outputs edge@%0t got busy/pass/fail/ovl/err/pc/fc/ffv/ffc=%h expected %h",
                   $time, got_v, exp_v);
        end
      end
    end
  end

  initial begin : stimulus
    logic [NUM_CH-1:0] g;
    repeat (3) drive(0, 0, 0, 0, '0, '0, 0);
    // STABLE on ch0 with gnt held low, then with gnt rising before k=DELAY
    drive(1, 1, 1, 0, 4'b0001, 4'b0000, 0);
    idle(4, 4'b0000);
    drive(1, 1, 1, 0, 4'b0001, 4'b0000, 0);
    idle(1, 4'b0000);
    idle(3, 4'b0001);
    // GRANT on ch2: late grant, then no grant
    drive(1, 1, 1, 1, 4'b0100, 4'b0000, 0);
    idle(1, 4'b0000);
    idle(2, 4'b0100);
    drive(1, 1, 1, 1, 4'b0100, 4'b0000, 0);
    idle(4, 4'b0000);
    // overlap at T+1, back-to-back accept at T+DELAY on ch1
    drive(1, 1, 1, 0, 4'b0010, 4'b0000, 0);
    drive(1, 1, 1, 0, 4'b0010, 4'b0000, 0);
    idle(1, 4'b0000);
    drive(1, 1, 1, 0, 4'b0010, 4'b0000, 0);
    idle(4, 4'b0000);
    // simultaneous GRANT fails on ch3 and ch1, then clr alongside a pass
    drive(1, 1, 1, 0, 4'b0000, 4'b0000, 1);
    drive(1, 1, 1, 1, 4'b1010, 4'b0000, 0);
    idle(3, 4'b0000);
    drive(1, 1, 1, 1, 4'b0001, 4'b0000, 0);
    drive(1, 1, 0, 0, 4'b0000, 4'b0001, 1);
    idle(2, 4'b0000);
    // saturate pass_cnt with back-to-back immediate grants, en=0 blocking
    for (int i = 0; i < 10; i++) drive(1, 1, 1, 1, 4'b1111, 4'b1111, 0);
    drive(1, 0, 1, 1, 4'b1111, 4'b1111, 0);
    // reset in the middle of a check
    drive(1, 1, 1, 0, 4'b1111, 4'b0000, 0);
    drive(0, 1, 0, 0, 4'b0000, 4'b0000, 0);
    idle(4, 4'b0000);
    // randomized traffic with occasional clr and reset
    g = '0;
    for (int i = 0; i < 3000; i++) begin
      for (int ch = 0; ch < NUM_CH; ch++)
        if ($urandom_range(0, 3) == 0) g[ch] = $urandom_range(0, 1);
      drive(($urandom_range(0, 199) != 0), ($urandom_range(0, 9) != 0),
            $urandom_range(0, 1), $urandom_range(0, 1),
            NUM_CH'($urandom_range(0, 15)), g, ($urandom_range(0, 39) == 0));
    end
    idle(DELAY + 2, '0);
    @(posedge clk);
    #2;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
